rvfi_check_sched: RTL and testbench

//   Sequences one formal check: owns the saturating cycle counter and

---
 rtl/rvfi_check_sched_pkg.sv | 14 +
 rtl/rvfi_check_sched_if.sv | 32 +++
 rtl/rvfi_check_sched_sat_counter.sv | 23 ++
 rtl/rvfi_check_sched.sv | 120 ++++++++++++
 tb/tb_rvfi_check_sched.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/rvfi_check_sched_pkg.sv
// rvfi_sched_pkg: shared types for the formal check scheduler.
// Holds the FSM state encoding and the default cycle counter width.
package rvfi_sched_pkg;

    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rvfi_check_sched_if.sv
// rvfi_check_sched_if: scheduler <-> checker/environment bundle.
// master (scheduler): takes trig_in/check_in, drives cycle,
// checker_reset, trig, check, state, done, order_err. slave: mirror.
interface rvfi_check_sched_if
    import rvfi_sched_pkg::*;
#(
    parameter int CW = CW_DEF
) ();

    logic          trig_in;
    logic          check_in;
    logic [CW-1:0] cycle;
    logic          checker_reset;
    logic          trig;
    logic          check;
    sched_state_t  state;
    logic          done;
    logic          order_err;

    modport master (
        input  trig_in, check_in,
        output cycle, checker_reset, trig, check,
        output state, done, order_err
    );

    modport slave (
        output trig_in, check_in,
        input  cycle, checker_reset, trig, check,
        input  state, done, order_err
    );

endinterface

// File: rtl/rvfi_check_sched_sat_counter.sv
// rvfi_sat_counter: saturating cycle counter, sync reset to 1.
// Ports: clock, reset (sync, active-high), cycle (0 while reset).
module rvfi_sat_counter #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] cycle
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= CW'(1);
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cycle = reset ? '0 : cnt_q;

endmodule

// File: rtl/rvfi_check_sched.sv
// rvfi_check_sched: sequences one formal check (reset window, trig, check).
// Ports: clock, reset (sync, active-high), bus (rvfi_check_sched_if.master).
// Macro RVFI_SCHED_UNBOUNDED_EN: trig/check requests come from trig_in/check_in.
module rvfi_check_sched
    import rvfi_sched_pkg::*;
#(
    parameter int          CW           = CW_DEF,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned TRIG_CYCLE   = 10,
    parameter int unsigned CHECK_CYCLE  = 15
) (
    input  logic                clock,
    input  logic                reset,
    rvfi_check_sched_if.master  bus
);

    logic [CW-1:0] cycle;
    logic [CW-1:0] cycle_nxt;
    logic [31:0]   cyc32;
    logic [31:0]   nxt32;
    logic          ckr;
    logic          next_ckr;
    logic          trig_req;
    logic          check_req;
    sched_state_t  state_q;
    sched_state_t  state_cur;
    sched_state_t  state_n;
    logic          trig;
    logic          check;

    rvfi_sat_counter #(.CW(CW)) u_cnt (
        .clock (clock),
        .reset (reset),
        .cycle (cycle)
    );

    // Value the counter will show next cycle; leaving S_RST on it lines
    // S_PRE up with the first cycle checker_reset is low.
    assign cycle_nxt = (cycle == '1) ? cycle : cycle + 1'b1;
    assign cyc32     = 32'(cycle);
    assign nxt32     = 32'(cycle_nxt);
    assign ckr       = cyc32 < RESET_CYCLES;
    assign next_ckr  = nxt32 < RESET_CYCLES;

`ifdef RVFI_SCHED_UNBOUNDED_EN
    logic err_q;
    logic err_set;

    assign trig_req  = bus.trig_in;
    assign check_req = bus.check_in;
    assign err_set   = (state_cur == S_PRE) & !ckr
                     & check_req & !trig_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.order_err = err_q;
`else
    assign trig_req      = (cyc32 == TRIG_CYCLE);
    assign check_req     = (cyc32 == CHECK_CYCLE);
    assign bus.order_err = 1'b0;
`endif

    // Reset overrides the registered state combinationally so pulses
    // and done drop in the very cycle reset is asserted.
    assign state_cur = reset ? S_RST : state_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        trig    = 1'b0;
        check   = 1'b0;
        unique case (state_cur)
            S_RST: begin
                if (!next_ckr) begin
                    state_n = S_PRE;
                end
            end
            S_PRE: begin
                if (!ckr && trig_req) begin
                    trig    = 1'b1;
                    check   = check_req;
                    state_n = check_req ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (!ckr && check_req) begin
                    check   = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_RST;
            end
        endcase
    end

    assign bus.cycle         = cycle;
    assign bus.checker_reset = ckr;
    assign bus.trig          = trig;
    assign bus.check         = check;
    assign bus.state         = state_cur;
    assign bus.done          = (state_cur == S_DONE);

endmodule

// File: tb/tb_rvfi_check_sched.sv
// tb_rvfi_check_sched: directed bench for the check scheduler.
// Four parameterisations share clock and reset; sampled 1 ns after negedge.
module tb_rvfi_check_sched;
    import rvfi_sched_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nvec  = 0;
    int   nerr  = 0;

    always #5 clock = ~clock;

    rvfi_check_sched_if #(.CW(8)) ia ();
    rvfi_check_sched_if #(.CW(8)) ib ();
    rvfi_check_sched_if #(.CW(4)) ic ();
    rvfi_check_sched_if #(.CW(8)) id ();

    rvfi_check_sched #(.CW(8)) dut_a (
        .clock (clock), .reset (reset), .bus (ia.master)
    );
    rvfi_check_sched #(
        .CW(8), .TRIG_CYCLE(5), .CHECK_CYCLE(5)
    ) dut_b (
        .clock (clock), .reset (reset), .bus (ib.master)
    );
    rvfi_check_sched #(
        .CW(4), .TRIG_CYCLE(20), .CHECK_CYCLE(25)
    ) dut_c (
        .clock (clock), .reset (reset), .bus (ic.master)
    );
    rvfi_check_sched #(
        .CW(8), .RESET_CYCLES(3), .TRIG_CYCLE(3), .CHECK_CYCLE(4)
    ) dut_d (
        .clock (clock), .reset (reset), .bus (id.master)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        tick();
        #1;
        chk("rst.cycle", 32'(ia.cycle), 0);
        chk("rst.ckr", 32'(ia.checker_reset), 1);
        chk("rst.trig", 32'(ia.trig), 0);
        chk("rst.check", 32'(ia.check), 0);
        chk("rst.done", 32'(ia.done), 0);
        chk("rst.err", 32'(ia.order_err), 0);
        chk("rst.state", 32'(ia.state), 32'(S_RST));
        chk("rst.c.cycle", 32'(ic.cycle), 0);
        reset = 1'b0;
        #1;
    endtask

    task automatic clr_in();
        ia.trig_in = 0; ia.check_in = 0;
        ib.trig_in = 0; ib.check_in = 0;
        ic.trig_in = 0; ic.check_in = 0;
        id.trig_in = 0; id.check_in = 0;
    endtask

`ifndef RVFI_SCHED_UNBOUNDED_EN
    task automatic check_bounded(input int k);
        sched_state_t ea, eb, ec, ed;
        ea = (k < 2) ? S_RST : (k <= 10) ? S_PRE :
             (k <= 15) ? S_POST : S_DONE;
        eb = (k < 2) ? S_RST : (k <= 5) ? S_PRE : S_DONE;
        ec = (k < 2) ? S_RST : S_PRE;
        ed = (k < 3) ? S_RST : (k == 3) ? S_PRE :
             (k == 4) ? S_POST : S_DONE;
        chk($sformatf("a.cycle@%0d", k), 32'(ia.cycle), k);
        chk($sformatf("a.ckr@%0d", k), 32'(ia.checker_reset), 0);
        chk($sformatf("a.trig@%0d", k), 32'(ia.trig), 32'(k == 10));
        chk($sformatf("a.check@%0d", k), 32'(ia.check), 32'(k == 15));
        chk($sformatf("a.done@%0d", k), 32'(ia.done), 32'(k >= 16));
        chk($sformatf("a.state@%0d", k), 32'(ia.state), 32'(ea));
        chk($sformatf("a.err@%0d", k), 32'(ia.order_err), 0);
        chk($sformatf("b.trig@%0d", k), 32'(ib.trig), 32'(k == 5));
        chk($sformatf("b.check@%0d", k), 32'(ib.check), 32'(k == 5));
        chk($sformatf("b.state@%0d", k), 32'(ib.state), 32'(eb));
        chk($sformatf("c.cycle@%0d", k), 32'(ic.cycle),
            (k > 15) ? 15 : k);
        chk($sformatf("c.trig@%0d", k), 32'(ic.trig), 0);
        chk($sformatf("c.state@%0d", k), 32'(ic.state), 32'(ec));
        chk($sformatf("d.ckr@%0d", k), 32'(id.checker_reset),
            32'(k < 3));
        chk($sformatf("d.trig@%0d", k), 32'(id.trig), 32'(k == 3));
        chk($sformatf("d.check@%0d", k), 32'(id.check), 32'(k == 4));
        chk($sformatf("d.state@%0d", k), 32'(id.state), 32'(ed));
    endtask
`endif

    initial begin
        clr_in();
`ifndef RVFI_SCHED_UNBOUNDED_EN
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) begin
                tick();
                ia.trig_in  = (k == 3);
                ia.check_in = (k == 3);
                #1;
            end
            check_bounded(k);
        end
        // Reset mid-check: dut_a sits in S_POST at cycle 12.
        do_reset();
        for (int k = 2; k <= 12; k++) tick();
        #1;
        chk("mid.a.state", 32'(ia.state), 32'(S_POST));
        tick();
        reset = 1'b1;
        #1;
        chk("mid.a.state", 32'(ia.state), 32'(S_RST));
        chk("mid.a.cycle", 32'(ia.cycle), 0);
        chk("mid.a.ckr", 32'(ia.checker_reset), 1);
        chk("mid.b.done", 32'(ib.done), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("mid.a.cycle1", 32'(ia.cycle), 1);
        chk("mid.a.state1", 32'(ia.state), 32'(S_RST));
        chk("mid.b.done1", 32'(ib.done), 0);
`else
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            ia.check_in = (k == 3) || (k == 6) || (k == 9);
            ia.trig_in  = (k == 6);
            id.trig_in  = 1'b1;
            #1;
            chk($sformatf("u4.err@%0d", k), 32'(ia.order_err),
                32'(k >= 4));
            chk($sformatf("u4.trig@%0d", k), 32'(ia.trig), 32'(k == 6));
            chk($sformatf("u4.check@%0d", k), 32'(ia.check),
                32'(k == 6));
            chk($sformatf("u4.done@%0d", k), 32'(ia.done), 32'(k >= 7));
            chk($sformatf("u6.trig@%0d", k), 32'(id.trig), 32'(k == 3));
        end
        clr_in();
        do_reset();
        for (int s = 1; s <= 14; s++) begin
            if (s > 1) begin
                tick();
                reset = (s == 7);
            end
            ib.trig_in = (s == 4) || (s == 12);
            #1;
            chk($sformatf("u5.trig@%0d", s), 32'(ib.trig),
                32'(s == 4 || s == 12));
            if (s == 5)
                chk("u5.post", 32'(ib.state), 32'(S_POST));
            if (s == 7) begin
                chk("u5.rst.state", 32'(ib.state), 32'(S_RST));
                chk("u5.rst.cycle", 32'(ib.cycle), 0);
            end
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
